bp_btb: RTL and testbench

Parametrised branch predictor for the five-stage RV32 core: a direct-mapped branch target buffer with 2-bit saturating counters and an optional gshare pattern table. It sits beside the PC register.
- **Fetch side:** it looks up the fetch PC combinationally and drives the PC mux's predicted-target input and the IF/ID predicted-taken bit.
- **Resolve side:** it is trained from the EXE stage once each branch or jump resolves.

---
 rtl/bp_btb.sv | 118 +++++++++++
 tb/tb_bp_btb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BP_GSHARE_EN to predict direction from a GHR-indexed pattern table instead.
module bp_btb #(
    parameter int ADDR_W  = 15,
    parameter int ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              stall,
    input  logic              upd_valid,
    input  logic              upd_cond,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush_all
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              validArr  [ENTRIES];
    logic [TAG_W-1:0]  tagArr    [ENTRIES];
    logic [ADDR_W-1:0] targetArr [ENTRIES];
    logic [1:0]        ctrArr    [ENTRIES];

    logic [IDX_W-1:0] lkIdx;
    logic [TAG_W-1:0] lkTag;
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             updHit;
    logic             updTaken;
    logic             applyUpd;
    logic             unusedPcBits;

    function automatic logic [1:0] satUpd(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        res = ctr;
        if (up && ctr != 2'b11)
            res = ctr + 2'd1;
        else if (!up && ctr != 2'b00)
            res = ctr - 2'd1;
        return res;
    endfunction

    assign lkIdx  = lk_pc[IDX_W+1:2];
    assign lkTag  = lk_pc[ADDR_W-1:IDX_W+2];
    assign updIdx = upd_pc[IDX_W+1:2];
    assign updTag = upd_pc[ADDR_W-1:IDX_W+2];

    // Byte offset within the instruction word never affects prediction.
    assign unusedPcBits = ^{lk_pc[1:0], upd_pc[1:0]};

    assign pred_hit    = validArr[lkIdx] && (tagArr[lkIdx] == lkTag);
    assign pred_target = pred_hit ? targetArr[lkIdx] : '0;

    // Jumps are always taken regardless of upd_taken.
    assign updTaken = !upd_cond || upd_taken;
    assign updHit   = validArr[updIdx] && (tagArr[updIdx] == updTag);
    assign applyUpd = upd_valid && !stall && !flush_all;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validArr[i]  <= 1'b0;
                tagArr[i]    <= '0;
                targetArr[i] <= '0;
                ctrArr[i]    <= 2'b01;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++)
                validArr[i] <= 1'b0;
        end else if (applyUpd) begin
            if (updHit) begin
                ctrArr[updIdx] <= upd_cond ? satUpd(ctrArr[updIdx], upd_taken) : 2'b11;
                if (updTaken)
                    targetArr[updIdx] <= upd_target;
            end else if (updTaken) begin
                // Allocation replaces whatever occupied the slot, valid or not.
                validArr[updIdx]  <= 1'b1;
                tagArr[updIdx]    <= updTag;
                targetArr[updIdx] <= upd_target;
                ctrArr[updIdx]    <= upd_cond ? 2'b10 : 2'b11;
            end
        end
    end

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;
    logic [1:0]       phtArr [ENTRIES];
    logic [IDX_W-1:0] lkXidx;
    logic [IDX_W-1:0] updXidx;

    assign lkXidx  = lkIdx ^ ghr;
    assign updXidx = updIdx ^ ghr;

    assign pred_taken = pred_hit && phtArr[lkXidx][1];

    // History is committed at resolve time only, so it is never speculative.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
            for (int i = 0; i < ENTRIES; i++)
                phtArr[i] <= 2'b01;
        end else if (flush_all) begin
            ghr <= '0;
        end else if (applyUpd && upd_cond) begin
            phtArr[updXidx] <= satUpd(phtArr[updXidx], upd_taken);
            ghr             <= {ghr[IDX_W-2:0], upd_taken};
        end
    end
`else
    assign pred_taken = pred_hit && ctrArr[lkIdx][1];
`endif

endmodule

// File: tb/tb_bp_btb.sv
// Directed bench for bp_btb (ADDR_W=15, ENTRIES=16): index = pc[5:2], tag = pc[14:6].
// Direction checks follow the bimodal or gshare model depending on BP_GSHARE_EN.
module tb_bp_btb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [14:0] lk_pc = '0;
    logic        pred_hit;
    logic        pred_taken;
    logic [14:0] pred_target;
    logic        stall = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_cond = 1'b0;
    logic [14:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [14:0] upd_target = '0;
    logic        flush_all = 1'b0;

    int nCompared   = 0;
    int nMismatched = 0;

    bp_btb #(.ADDR_W(15), .ENTRIES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .lk_pc      (lk_pc),
        .pred_hit   (pred_hit),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .stall      (stall),
        .upd_valid  (upd_valid),
        .upd_cond   (upd_cond),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .flush_all  (flush_all)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One lookup; direction is only compared when chkTaken is set.
    task automatic look(input string tag, input logic [14:0] pc, input logic expHit,
                        input logic chkTaken, input logic expTaken, input logic [14:0] expTarget);
        lk_pc = pc;
        #1;
        checkVal({tag, ".hit"}, 32'(pred_hit), 32'(expHit));
        if (chkTaken)
            checkVal({tag, ".taken"}, 32'(pred_taken), 32'(expTaken));
        checkVal({tag, ".target"}, 32'(pred_target), 32'(expTarget));
    endtask

    task automatic doUpd(input logic cond, input logic [14:0] pc, input logic taken,
                         input logic [14:0] target);
        upd_valid  = 1'b1;
        upd_cond   = cond;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = target;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

`ifndef BP_GSHARE_EN
    localparam logic BIM = 1'b1;
`else
    localparam logic BIM = 1'b0;
`endif

    initial begin
        // Reset: asynchronous, outputs clear while held and after release
        #2;
        look("rst_held", 15'h0040, 1'b0, 1'b1, 1'b0, 15'h0000);
        tick();
        rst = 1'b1;
        look("rst_rel", 15'h0040, 1'b0, 1'b1, 1'b0, 15'h0000);

        // Allocate and weaken
        doUpd(1'b1, 15'h0100, 1'b1, 15'h0200);
        look("alloc", 15'h0100, 1'b1, BIM, 1'b1, 15'h0200);
        doUpd(1'b1, 15'h0100, 1'b0, 15'h0000);
        look("weaken", 15'h0100, 1'b1, BIM, 1'b0, 15'h0200);

        // Saturation: 01 -> 11 after four taken, then 10, then 01/00/00
        repeat (4) doUpd(1'b1, 15'h0100, 1'b1, 15'h0200);
        doUpd(1'b1, 15'h0100, 1'b0, 15'h0000);
        look("sat_1nt", 15'h0100, 1'b1, BIM, 1'b1, 15'h0200);
        repeat (3) doUpd(1'b1, 15'h0100, 1'b0, 15'h0000);
        look("sat_4nt", 15'h0100, 1'b1, BIM, 1'b0, 15'h0200);

        // Aliasing on index 0; same-cycle lookup sees pre-update contents
        look("alias_miss", 15'h0140, 1'b0, 1'b1, 1'b0, 15'h0000);
        upd_valid = 1'b1; upd_cond = 1'b1; upd_pc = 15'h0140;
        upd_taken = 1'b1; upd_target = 15'h0300;
        look("alias_same_cyc", 15'h0140, 1'b0, 1'b1, 1'b0, 15'h0000);
        tick();
        upd_valid = 1'b0;
        look("alias_new", 15'h0140, 1'b1, 1'b0, 1'b0, 15'h0300);
        look("alias_old", 15'h0100, 1'b0, 1'b1, 1'b0, 15'h0000);

        // Stall holds an update until the first unstalled edge
        upd_valid = 1'b1; upd_cond = 1'b1; upd_pc = 15'h0080;
        upd_taken = 1'b1; upd_target = 15'h0400; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            look($sformatf("stall%0d", i), 15'h0080, 1'b0, 1'b1, 1'b0, 15'h0000);
        end
        stall = 1'b0;
        tick();
        upd_valid = 1'b0;
        look("stall_rel", 15'h0080, 1'b1, BIM, 1'b1, 15'h0400);
        doUpd(1'b1, 15'h0080, 1'b0, 15'h0000);
        look("stall_ctr10", 15'h0080, 1'b1, BIM, 1'b0, 15'h0400);

        // Not-taken conditional miss allocates nothing
        doUpd(1'b1, 15'h0104, 1'b0, 15'h0700);
        look("nt_miss", 15'h0104, 1'b0, 1'b1, 1'b0, 15'h0000);

        // Jump allocates with ctr=11 even if upd_taken is low
        doUpd(1'b0, 15'h0108, 1'b0, 15'h0500);
        look("jump_alloc", 15'h0108, 1'b1, BIM, 1'b1, 15'h0500);
        doUpd(1'b1, 15'h0108, 1'b0, 15'h0000);
        look("jump_ctr11", 15'h0108, 1'b1, BIM, 1'b1, 15'h0500);

        // Flush overrides a concurrent update
        flush_all = 1'b1;
        doUpd(1'b1, 15'h010C, 1'b1, 15'h0600);
        flush_all = 1'b0;
        look("flush_upd", 15'h010C, 1'b0, 1'b1, 1'b0, 15'h0000);
        look("flush_080", 15'h0080, 1'b0, 1'b1, 1'b0, 15'h0000);
        look("flush_108", 15'h0108, 1'b0, 1'b1, 1'b0, 15'h0000);

        // Reset asserted during an update discards it
        doUpd(1'b1, 15'h0100, 1'b1, 15'h0200);
        upd_valid = 1'b1; upd_cond = 1'b1; upd_pc = 15'h0110;
        upd_taken = 1'b1; upd_target = 15'h0210;
        rst = 1'b0;
        tick();
        upd_valid = 1'b0;
        rst = 1'b1;
        look("rstmid_110", 15'h0110, 1'b0, 1'b1, 1'b0, 15'h0000);
        look("rstmid_100", 15'h0100, 1'b0, 1'b1, 1'b0, 15'h0000);

`ifdef BP_GSHARE_EN
        // Gshare: history-indexed pattern table replaces per-entry counters
        resetDut();
        doUpd(1'b0, 15'h0100, 1'b1, 15'h0200);
        look("gs_jump", 15'h0100, 1'b1, 1'b1, 1'b0, 15'h0200);
        // GHR 0->1->3->7->F; pattern entries 1,3,2,5 trained
        doUpd(1'b1, 15'h0204, 1'b1, 15'h0010);
        doUpd(1'b1, 15'h0208, 1'b1, 15'h0010);
        doUpd(1'b1, 15'h0244, 1'b1, 15'h0010);
        doUpd(1'b1, 15'h0248, 1'b1, 15'h0010);
        for (int r = 0; r < 2; r++) begin
            doUpd(1'b1, 15'h0100, 1'b0, 15'h0000);
            // GHR E->D->B->7->F without touching pattern entry F
            doUpd(1'b1, 15'h0208, 1'b1, 15'h0010);
            doUpd(1'b1, 15'h0204, 1'b1, 15'h0010);
            doUpd(1'b1, 15'h0244, 1'b1, 15'h0010);
            doUpd(1'b1, 15'h0248, 1'b1, 15'h0010);
        end
        look("gs_ghrF_nt", 15'h0100, 1'b1, 1'b1, 1'b0, 15'h0200);
        // One taken lifts pht[F] from 00 only to 01, still not taken
        doUpd(1'b1, 15'h0100, 1'b1, 15'h0200);
        doUpd(1'b1, 15'h0208, 1'b1, 15'h0010);
        doUpd(1'b1, 15'h0204, 1'b1, 15'h0010);
        doUpd(1'b1, 15'h0244, 1'b1, 15'h0010);
        doUpd(1'b1, 15'h0248, 1'b1, 15'h0010);
        look("gs_ghrF_01", 15'h0100, 1'b1, 1'b1, 1'b0, 15'h0200);
        // Flush clears GHR: idx0 uses untouched pht[0], idx1 uses pht[1]=10
        flush_all = 1'b1;
        tick();
        flush_all = 1'b0;
        doUpd(1'b0, 15'h0100, 1'b1, 15'h0220);
        doUpd(1'b0, 15'h0104, 1'b1, 15'h0230);
        look("gs_ghr0_pc100", 15'h0100, 1'b1, 1'b1, 1'b0, 15'h0220);
        look("gs_ghr0_pc104", 15'h0104, 1'b1, 1'b1, 1'b1, 15'h0230);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
